// File: rtl/sdrc_wb_mport_arb.sv
// Multi-port Wishbone classic front end for sdrc_core: arbitrates NPORT single-beat
// slave ports (round-robin or fixed priority) onto the single app request/data interface.
module sdrc_wb_mport_arb #(
  parameter int unsigned NPORT  = 4,
  parameter int unsigned APP_AW = 26,
  parameter int unsigned DW     = 32,
  parameter int unsigned BL     = 9
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      cfg_arb_mode,
  input  logic [NPORT-1:0]          cfg_port_en,
  input  logic [NPORT-1:0]          wb_cyc_i,
  input  logic [NPORT-1:0]          wb_stb_i,
  input  logic [NPORT-1:0]          wb_we_i,
  input  logic [NPORT*APP_AW-1:0]   wb_addr_i,
  input  logic [NPORT*DW-1:0]       wb_dat_i,
  input  logic [NPORT*(DW/8)-1:0]   wb_sel_i,
  output logic [NPORT-1:0]          wb_ack_o,
  output logic [NPORT*DW-1:0]       wb_dat_o,
  output logic                      app_req,
  output logic [APP_AW-1:0]         app_req_addr,
  output logic [BL-1:0]             app_req_len,
  output logic                      app_req_wr_n,
  input  logic                      app_req_ack,
  output logic [DW-1:0]             app_wr_data,
  output logic [DW/8-1:0]           app_wr_en_n,
  input  logic                      app_wr_next_req,
  input  logic [DW-1:0]             app_rd_data,
  input  logic                      app_rd_valid,
  output logic                      arb_busy,
  output logic [$clog2(NPORT)-1:0]  arb_grant
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned GW = $clog2(NPORT);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_ACK  = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [GW-1:0]     grant_nxt, rr_ptr, rr_ptr_nxt, win;
  logic              cyc_lost, cyc_lost_nxt;
  logic              app_req_nxt, wr_n_nxt, rd_cap;
  logic [APP_AW-1:0] addr_nxt;
  logic [DW-1:0]     wdata_nxt;
  logic [SW-1:0]     en_n_nxt;
  logic [NPORT-1:0]  ack_nxt, pending;
  logic              grant_cyc;

  logic [APP_AW-1:0] port_addr [NPORT];
  logic [DW-1:0]     port_dat  [NPORT];
  logic [SW-1:0]     port_sel  [NPORT];
  logic [DW-1:0]     rdat_q    [NPORT];

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign port_addr[p]          = wb_addr_i[p*APP_AW +: APP_AW];
    assign port_dat[p]           = wb_dat_i[p*DW +: DW];
    assign port_sel[p]           = wb_sel_i[p*SW +: SW];
    assign wb_dat_o[p*DW +: DW]  = rdat_q[p];
  end

  // First requesting port at or above base, wrapping; base 0 gives fixed priority.
  function automatic logic [GW-1:0] pick_winner(input logic [NPORT-1:0] req,
                                                 input logic [GW-1:0]    base);
    logic [GW-1:0] w;
    logic          found;
    int unsigned   k;
    w     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      k = (32'(base) + i) % NPORT;
      if (!found && req[GW'(k)]) begin
        w     = GW'(k);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign pending     = wb_cyc_i & wb_stb_i & cfg_port_en;
  assign win         = pick_winner(pending, cfg_arb_mode ? '0 : rr_ptr);
  assign grant_cyc   = wb_cyc_i[arb_grant];
  assign app_req_len = BL'(1);

  always_comb begin : p_next
    state_nxt    = state;
    grant_nxt    = arb_grant;
    rr_ptr_nxt   = rr_ptr;
    cyc_lost_nxt = cyc_lost;
    app_req_nxt  = app_req;
    addr_nxt     = app_req_addr;
    wr_n_nxt     = app_req_wr_n;
    wdata_nxt    = app_wr_data;
    en_n_nxt     = app_wr_en_n;
    ack_nxt      = '0;
    rd_cap       = 1'b0;
    case (state)
      ST_IDLE: begin
        cyc_lost_nxt = 1'b0;
        if (|pending) begin
          state_nxt   = ST_REQ;
          grant_nxt   = win;
          app_req_nxt = 1'b1;
          addr_nxt    = port_addr[win];
          wr_n_nxt    = ~wb_we_i[win];
          wdata_nxt   = port_dat[win];
          en_n_nxt    = wb_we_i[win] ? ~port_sel[win] : '1;
        end
      end
      ST_REQ: begin
        // Core acceptance takes precedence over a simultaneous cyc drop.
        if (app_req_ack) begin
          app_req_nxt = 1'b0;
          state_nxt   = app_req_wr_n ? ST_RD : ST_WR;
        end else if (!grant_cyc) begin
          app_req_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      ST_WR: begin
        cyc_lost_nxt = cyc_lost | ~grant_cyc;
        if (app_wr_next_req) begin
          state_nxt          = ST_ACK;
          ack_nxt[arb_grant] = ~cyc_lost_nxt;
        end
      end
      ST_RD: begin
        cyc_lost_nxt = cyc_lost | ~grant_cyc;
        if (app_rd_valid) begin
          state_nxt          = ST_ACK;
          rd_cap             = 1'b1;
          ack_nxt[arb_grant] = ~cyc_lost_nxt;
        end
      end
      ST_ACK: begin
        state_nxt  = ST_IDLE;
        rr_ptr_nxt = (arb_grant == GW'(NPORT - 1)) ? '0 : arb_grant + GW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin : p_regs
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      arb_grant    <= '0;
      rr_ptr       <= '0;
      cyc_lost     <= 1'b0;
      app_req      <= 1'b0;
      app_req_addr <= '0;
      app_req_wr_n <= 1'b1;
      app_wr_data  <= '0;
      app_wr_en_n  <= '1;
      wb_ack_o     <= '0;
      arb_busy     <= 1'b0;
      rdat_q       <= '{default: '0};
    end else begin
      state        <= state_nxt;
      arb_grant    <= grant_nxt;
      rr_ptr       <= rr_ptr_nxt;
      cyc_lost     <= cyc_lost_nxt;
      app_req      <= app_req_nxt;
      app_req_addr <= addr_nxt;
      app_req_wr_n <= wr_n_nxt;
      app_wr_data  <= wdata_nxt;
      app_wr_en_n  <= en_n_nxt;
      wb_ack_o     <= ack_nxt;
      arb_busy     <= (state_nxt != ST_IDLE);
      if (rd_cap) rdat_q[arb_grant] <= app_rd_data;
    end
  end

endmodule

// File: tb/tb_sdrc_wb_mport_arb.sv
// Bench for sdrc_wb_mport_arb: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sdrc_wb_mport_arb;
  localparam int NP = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int BL = 9;
  localparam int GW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               wb_rst_i, cfg_arb_mode;
  logic [NP-1:0]      cfg_port_en, wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [NP*AW-1:0]   wb_addr_i;
  logic [NP*DW-1:0]   wb_dat_i, wb_dat_o;
  logic [NP*SW-1:0]   wb_sel_i;
  logic               app_req, app_req_wr_n, app_req_ack, app_wr_next_req, app_rd_valid, arb_busy;
  logic [AW-1:0]      app_req_addr;
  logic [BL-1:0]      app_req_len;
  logic [DW-1:0]      app_wr_data, app_rd_data;
  logic [SW-1:0]      app_wr_en_n;
  logic [GW-1:0]      arb_grant;

  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_dat  [NP];
  logic [SW-1:0] p_sel  [NP];
  logic [DW-1:0] dat_o_a [NP];

  for (genvar g = 0; g < NP; g++) begin : g_bus
    assign wb_addr_i[g*AW +: AW] = p_addr[g];
    assign wb_dat_i[g*DW +: DW]  = p_dat[g];
    assign wb_sel_i[g*SW +: SW]  = p_sel[g];
    assign dat_o_a[g]            = wb_dat_o[g*DW +: DW];
  end

  sdrc_wb_mport_arb #(.NPORT(NP), .APP_AW(AW), .DW(DW), .BL(BL)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .cfg_arb_mode(cfg_arb_mode), .cfg_port_en(cfg_port_en),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack), .app_wr_data(app_wr_data),
    .app_wr_en_n(app_wr_en_n), .app_wr_next_req(app_wr_next_req), .app_rd_data(app_rd_data),
    .app_rd_valid(app_rd_valid), .arb_busy(arb_busy), .arb_grant(arb_grant)
  );

  // ---------------- transaction-level model ----------------
  logic          exp_req, exp_wr_n, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_en_n;
  logic [NP-1:0] exp_ack;
  logic [GW-1:0] exp_grant;
  logic [DW-1:0] exp_dat [NP];
  int            m_rr;
  int            grant_log [$];

  task automatic reset_exp();
    exp_req = 1'b0; exp_wr_n = 1'b1; exp_busy = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_en_n = '1; exp_ack = '0; exp_grant = '0; m_rr = 0;
    for (int p = 0; p < NP; p++) exp_dat[GW'(p)] = '0;
  endtask

  task automatic tick(output bit r);
    @(posedge clk);
    r = wb_rst_i;
    if (r) reset_exp();
  endtask

  // One whole transaction of port w, from the arbitration edge to the return to idle.
  task automatic model_txn(input int w);
    bit r, we, lost;
    we        = wb_we_i[GW'(w)];
    exp_grant = GW'(w);
    exp_req   = 1'b1;
    exp_busy  = 1'b1;
    exp_addr  = p_addr[GW'(w)];
    exp_wr_n  = !we;
    exp_wdata = p_dat[GW'(w)];
    exp_en_n  = we ? ~p_sel[GW'(w)] : '1;
    grant_log.push_back(w);
    forever begin
      tick(r); if (r) return;
      if (app_req_ack) break;
      if (!wb_cyc_i[GW'(w)]) begin exp_req = 1'b0; exp_busy = 1'b0; return; end
    end
    exp_req = 1'b0;
    lost = 1'b0;
    forever begin
      tick(r); if (r) return;
      lost = lost | !wb_cyc_i[GW'(w)];
      if (we ? app_wr_next_req : app_rd_valid) break;
    end
    if (!we) exp_dat[GW'(w)] = app_rd_data;
    exp_ack = '0;
    exp_ack[GW'(w)] = !lost;
    tick(r); if (r) return;
    exp_ack  = '0;
    exp_busy = 1'b0;
    m_rr     = (w + 1) % NP;
  endtask

  initial begin : model
    bit r;
    logic [NP-1:0] pend;
    int w, k;
    reset_exp();
    forever begin
      tick(r);
      if (!r) begin
        pend = wb_cyc_i & wb_stb_i & cfg_port_en;
        if (pend != '0) begin
          w = -1;
          for (int i = 0; i < NP; i++) begin
            k = cfg_arb_mode ? i : (m_rr + i) % NP;
            if (w < 0 && pend[GW'(k)]) w = k;
          end
          model_txn(w);
        end
      end
    end
  end

  // ---------------- checking ----------------
  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;
  int ack_cnt [NP];
  int ack_base [NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic compare_all();
    chk("app_req", 64'(app_req), 64'(exp_req));
    chk("app_req_addr", 64'(app_req_addr), 64'(exp_addr));
    chk("app_req_wr_n", 64'(app_req_wr_n), 64'(exp_wr_n));
    chk("app_wr_data", 64'(app_wr_data), 64'(exp_wdata));
    chk("app_wr_en_n", 64'(app_wr_en_n), 64'(exp_en_n));
    chk("app_req_len", 64'(app_req_len), 64'(1));
    chk("wb_ack_o", 64'(wb_ack_o), 64'(exp_ack));
    chk("arb_busy", 64'(arb_busy), 64'(exp_busy));
    chk("arb_grant", 64'(arb_grant), 64'(exp_grant));
    for (int p = 0; p < NP; p++)
      chk($sformatf("wb_dat_o[%0d]", p), 64'(dat_o_a[GW'(p)]), 64'(exp_dat[GW'(p)]));
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) compare_all();
    for (int p = 0; p < NP; p++) if (wb_ack_o[GW'(p)]) ack_cnt[GW'(p)]++;
  endtask

  task automatic snap();
    for (int p = 0; p < NP; p++) ack_base[GW'(p)] = ack_cnt[GW'(p)];
  endtask

  function automatic int acks(input int p);
    return ack_cnt[GW'(p)] - ack_base[GW'(p)];
  endfunction

  function automatic int acks_all();
    int s = 0;
    for (int p = 0; p < NP; p++) s += acks(p);
    return s;
  endfunction

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    wb_we_i[GW'(p)] = we; p_addr[GW'(p)] = a; p_dat[GW'(p)] = d; p_sel[GW'(p)] = s;
    wb_cyc_i[GW'(p)] = 1'b1; wb_stb_i[GW'(p)] = 1'b1;
  endtask

  task automatic drop(input int p);
    wb_cyc_i[GW'(p)] = 1'b0; wb_stb_i[GW'(p)] = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!app_req && n < 40) begin step(); n++; end
    chk(nm, 64'(app_req), 64'(1));
  endtask

  task automatic wait_ack(input int p, input string nm);
    int n = 0;
    while (!wb_ack_o[GW'(p)] && n < 40) begin step(); n++; end
    chk(nm, 64'(wb_ack_o[GW'(p)]), 64'(1));
  endtask

  task automatic auto_core(input logic on);
    app_req_ack = on; app_wr_next_req = on; app_rd_valid = on;
  endtask

  int rr_order [6] = '{0, 1, 2, 3, 0, 1};
  int fx_order [4] = '{0, 0, 0, 3};

  initial begin : stim
    int n, lb, cyc_no;
    cyc_no = 0;
    for (int p = 0; p < NP; p++) begin
      ack_cnt[GW'(p)] = 0; ack_base[GW'(p)] = 0;
      p_addr[GW'(p)] = '0; p_dat[GW'(p)] = '0; p_sel[GW'(p)] = '0;
    end
    wb_rst_i = 1'b1; cfg_arb_mode = 1'b0; cfg_port_en = '1;
    wb_cyc_i = '0; wb_stb_i = '0; wb_we_i = '0;
    app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_rd_valid = 1'b0; app_rd_data = '0;

    // Reset values
    step(); step();
    chk_en = 1'b1;
    step();
    chk("rst_app_req", 64'(app_req), 64'(0));
    chk("rst_wr_n", 64'(app_req_wr_n), 64'(1));
    chk("rst_en_n", 64'(app_wr_en_n), 64'(4'hF));
    chk("rst_busy", 64'(arb_busy), 64'(0));
    chk("rst_grant", 64'(arb_grant), 64'(0));
    wb_rst_i = 1'b0;
    step();

    // Port 1 write; wr_next during REQ must be ignored
    snap();
    set_port(1, 1'b1, 26'h0000100, 32'hDEADBEEF, 4'b0011);
    wait_req("t1_req");
    app_wr_next_req = 1'b1; step(); app_wr_next_req = 1'b0; step();
    app_req_ack = 1'b1; step(); app_req_ack = 1'b0;
    step(); step();
    app_wr_next_req = 1'b1; step(); app_wr_next_req = 1'b0;
    wait_ack(1, "t1_ack");
    chk("t1_wdata", 64'(app_wr_data), 64'(32'hDEADBEEF));
    chk("t1_en_n", 64'(app_wr_en_n), 64'(4'b1100));
    chk("t1_len", 64'(app_req_len), 64'(1));
    chk("t1_addr", 64'(app_req_addr), 64'(26'h100));
    chk("t1_ackvec", 64'(wb_ack_o), 64'(4'b0010));
    drop(1);
    step(); step(); step();
    chk("t1_ack_once", 64'(acks(1)), 64'(1));
    chk("t1_idle", 64'(arb_busy), 64'(0));

    // Port 2 read
    snap();
    set_port(2, 1'b0, 26'h0000200, 32'h0, 4'hF);
    wait_req("t2_req");
    chk("t2_wr_n", 64'(app_req_wr_n), 64'(1));
    chk("t2_en_n", 64'(app_wr_en_n), 64'(4'hF));
    app_req_ack = 1'b1; step(); app_req_ack = 1'b0;
    step(); step();
    app_rd_data = 32'h12345678; app_rd_valid = 1'b1; step();
    app_rd_valid = 1'b0; app_rd_data = 32'hFFFFFFFF;
    wait_ack(2, "t2_ack");
    chk("t2_dat2", 64'(dat_o_a[2]), 64'(32'h12345678));
    chk("t2_dat0", 64'(dat_o_a[0]), 64'(0));
    chk("t2_dat1", 64'(dat_o_a[1]), 64'(0));
    chk("t2_dat3", 64'(dat_o_a[3]), 64'(0));
    drop(2);
    step(); step();
    chk("t2_ack_once", 64'(acks(2)), 64'(1));

    // Round-robin, all ports reading continuously
    wb_rst_i = 1'b1; step(); step(); wb_rst_i = 1'b0;
    snap(); lb = grant_log.size();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(p * 16), 32'h0, 4'hF);
    auto_core(1'b1);
    n = 0;
    while (acks_all() < 4 && n < 100) begin app_rd_data = 32'hA0000000 + 32'(cyc_no); cyc_no++; step(); n++; end
    for (int p = 0; p < NP; p++) chk($sformatf("rr_once_p%0d", p), 64'(acks(p)), 64'(1));
    while (acks_all() < 6 && n < 100) begin app_rd_data = 32'hA0000000 + 32'(cyc_no); cyc_no++; step(); n++; end
    for (int p = 0; p < NP; p++) drop(p);
    auto_core(1'b0);
    step(); step(); step();
    chk("rr_log_len", 64'(grant_log.size() - lb), 64'(6));
    for (int i = 0; i < 6 && lb + i < grant_log.size(); i++)
      chk($sformatf("rr_order%0d", i), 64'(grant_log[lb + i]), 64'(rr_order[i]));
    chk("rr_cnt0", 64'(acks(0)), 64'(2));
    chk("rr_cnt1", 64'(acks(1)), 64'(2));
    chk("rr_cnt2", 64'(acks(2)), 64'(1));
    chk("rr_cnt3", 64'(acks(3)), 64'(1));

    // Fixed priority, ports 0 and 3 continuously
    cfg_arb_mode = 1'b1;
    snap(); lb = grant_log.size();
    set_port(0, 1'b0, 26'h0000040, 32'h0, 4'hF);
    set_port(3, 1'b0, 26'h0000070, 32'h0, 4'hF);
    auto_core(1'b1);
    n = 0;
    while (acks(0) < 3 && n < 100) begin app_rd_data = 32'hB0000000 + 32'(cyc_no); cyc_no++; step(); n++; end
    chk("fx_p3_starved", 64'(acks(3)), 64'(0));
    drop(0);
    while (acks(3) < 1 && n < 100) begin app_rd_data = 32'hB0000000 + 32'(cyc_no); cyc_no++; step(); n++; end
    drop(3);
    auto_core(1'b0);
    step(); step(); step();
    chk("fx_log_len", 64'(grant_log.size() - lb), 64'(4));
    for (int i = 0; i < 4 && lb + i < grant_log.size(); i++)
      chk($sformatf("fx_order%0d", i), 64'(grant_log[lb + i]), 64'(fx_order[i]));
    chk("fx_cnt0", 64'(acks(0)), 64'(3));
    chk("fx_cnt3", 64'(acks(3)), 64'(1));

    // Disabled port never granted; port 2 abandons its request in REQ
    cfg_arb_mode = 1'b0; cfg_port_en = 4'b1101;
    snap();
    set_port(1, 1'b1, 26'h0000111, 32'h11111111, 4'hF);
    for (int i = 0; i < 10; i++) begin step(); chk($sformatf("dis_busy%0d", i), 64'(arb_busy), 64'(0)); end
    drop(1);
    set_port(2, 1'b0, 26'h0000222, 32'h0, 4'hF);
    wait_req("ab_req");
    step(); step();
    drop(2);
    step();
    chk("ab_app_req", 64'(app_req), 64'(0));
    chk("ab_busy", 64'(arb_busy), 64'(0));
    step(); step(); step(); step(); step();
    chk("ab_no_ack2", 64'(acks(2)), 64'(0));
    chk("dis_no_ack1", 64'(acks(1)), 64'(0));

    // Reset while waiting for read data
    cfg_port_en = '1;
    snap();
    set_port(0, 1'b0, 26'h0000300, 32'h0, 4'hF);
    wait_req("rs_req");
    app_req_ack = 1'b1; step(); app_req_ack = 1'b0;
    step();
    chk("rs_busy_rd", 64'(arb_busy), 64'(1));
    wb_rst_i = 1'b1; drop(0);
    step();
    wb_rst_i = 1'b0;
    chk("rs_app_req", 64'(app_req), 64'(0));
    chk("rs_busy", 64'(arb_busy), 64'(0));
    chk("rs_grant", 64'(arb_grant), 64'(0));
    app_rd_data = 32'hCAFEF00D; app_rd_valid = 1'b1; step(); app_rd_valid = 1'b0;
    step(); step(); step(); step();
    chk("rs_no_ack", 64'(acks(0)), 64'(0));
    chk("rs_dat0", 64'(dat_o_a[0]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdrc_wb_mport_arb.md
Name: sdrc_wb_mport_arb

Overview:
- Parametrised multi-port Wishbone front end for the SDRAM controller core; successor to the single-port Wishbone bridge at the controller top.
- Accepts NPORT independent Wishbone classic single-beat slave ports and arbitrates them onto the single app request/data interface of sdrc_core.
- Arbitration is round-robin or fixed-priority, selected at run time, with per-port enables.
- Sits in the sdram_clk domain; one clock, no CDC.

Parameters:
- NPORT, 4, number of Wishbone slave ports (2..8).
- APP_AW, 26, application address width.
- DW, 32, data width; DW/8 byte lanes.
- BL, 9, width of app_req_len.

Ports:
- wb_clk_i  in  1  clock; also clocks the app interface.
- wb_rst_i  in  1  synchronous, active-high reset.
- cfg_arb_mode  in  1  0 = round-robin, 1 = fixed priority (port 0 highest).
- cfg_port_en  in  NPORT  per-port enable; a disabled port is never granted.
- wb_cyc_i  in  NPORT  per-port cycle.
- wb_stb_i  in  NPORT  per-port strobe.
- wb_we_i  in  NPORT  per-port write enable.
- wb_addr_i  in  NPORT*APP_AW  packed addresses; port p at [p*APP_AW +: APP_AW].
- wb_dat_i  in  NPORT*DW  packed write data.
- wb_sel_i  in  NPORT*DW/8  packed byte selects.
- wb_ack_o  out  NPORT  per-port acknowledge.
- wb_dat_o  out  NPORT*DW  packed per-port read data.
- app_req  out  1  request to the core.
- app_req_addr  out  APP_AW  request address.
- app_req_len  out  BL  burst length; constant 1.
- app_req_wr_n  out  1  0 = write, 1 = read.
- app_req_ack  in  1  core accepted the request.
- app_wr_data  out  DW  write data.
- app_wr_en_n  out  DW/8  active-low byte enables.
- app_wr_next_req  in  1  core consumes write data this cycle.
- app_rd_data  in  DW  read data.
- app_rd_valid  in  1  read data valid.
- arb_busy  out  1  a transaction is in progress (state not IDLE).
- arb_grant  out  $clog2(NPORT)  index of the current or last granted port.

Behaviour:
- Reset (sync, wb_rst_i=1 at posedge):
  - state = IDLE; wb_ack_o = 0; wb_dat_o = 0; app_req = 0; app_req_addr = 0; app_req_wr_n = 1; app_wr_data = 0.
  - app_wr_en_n = all ones; arb_busy = 0; arb_grant = 0; rr_ptr = 0.
  - Reset mid-transaction discards the transaction; no ack is issued.
- Pending vector = wb_cyc_i & wb_stb_i & cfg_port_en.
- IDLE:
  - If pending is nonzero, select a winner:
    - fixed mode: lowest set index;
    - round-robin mode: first set index at or above rr_ptr, wrapping modulo NPORT.
  - Latch the winner's index, addr, we, dat and sel. Next cycle: state = REQ, app_req = 1.
  - Request fields are registered; latency from stb to app_req is 1 cycle.
- REQ:
  - app_req and all app fields are held stable.
  - app_req_addr = latched addr; app_req_wr_n = ~we; app_wr_data = latched dat; app_wr_en_n = ~latched sel (reads: all ones).
  - On app_req_ack=1: app_req = 0 next cycle; go to WR if we, else RD.
  - If the granted port's wb_cyc_i drops before app_req_ack: drop app_req, go to IDLE, no ack, rr_ptr unchanged.
  - If app_req_ack and the cyc drop occur in the same cycle, the ack wins and the transaction completes.
- WR:
  - Data and enables are held. On app_wr_next_req=1 go to ACK.
  - app_wr_next_req asserted while in REQ is ignored.
- RD:
  - On app_rd_valid=1 capture app_rd_data into the granted port's wb_dat_o slice, then go to ACK.
  - Other ports' wb_dat_o slices are unchanged.
- ACK:
  - wb_ack_o[grant] = 1 for exactly one cycle, then go to IDLE.
  - The ack is suppressed if the granted port's wb_cyc_i dropped after app_req_ack; the SDRAM access still completes.
  - rr_ptr = (grant+1) mod NPORT, updated in both arbitration modes.
- Timing:
  - At most one app transaction is outstanding.
  - Minimum turnaround is 1 cycle of ACK followed by re-arbitration in IDLE; there is no back-to-back grant without IDLE.
  - A port whose stb is still high in the IDLE cycle after its ack is treated as a new request.
- Configuration changes:
  - cfg_port_en and cfg_arb_mode are sampled only in IDLE.
  - Clearing an enable while that port is granted does not abort its transaction.
- arb_busy = (state != IDLE). arb_grant holds the latched index.

Test Plan:
- Reset → all outputs at reset values. Port 1 write, addr 0x0000100, dat 0xDEADBEEF, sel 4'b0011; core acks after 3 cycles, wr_next 2 cycles later → app_wr_data = 0xDEADBEEF, app_wr_en_n = 4'b1100, app_req_len = 1, single wb_ack_o[1].
- Port 2 read, addr 0x0000200; core returns 0x12345678 → wb_dat_o slice 2 = 0x12345678 when wb_ack_o[2] = 1; slices 0, 1 and 3 unchanged.
- Round-robin: all 4 ports continuously requesting reads → grant order 0, 1, 2, 3, 0, 1; each port acked once per 4 transactions.
- Fixed mode, ports 0 and 3 continuously requesting → only port 0 is granted; after port 0 drops stb, port 3 is granted.
- cfg_port_en = 4'b1101 with port 1 requesting → never granted, arb_busy stays 0. Port 2 drops cyc in REQ before app_req_ack → app_req deasserts, no ack issued.
- wb_rst_i asserted while in RD → next cycle state IDLE, app_req = 0, no wb_ack_o; a later app_rd_valid is ignored.
